// File: rtl/step_sequencer_pkg.sv
// Shared types and helpers for the step sequencer.
package step_seq_pkg;

   // Sequencer control states
   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Clamp a requested last-step index to the highest step that exists.
   function automatic int unsigned sat_last(input int unsigned last, input int unsigned steps);
      int unsigned top;
      top = steps - 32'd1;
      if (last > top) begin
         return top;
      end else begin
         return last;
      end
   endfunction

endpackage

// File: rtl/step_sequencer_if.sv
// Control/status bundle between the control unit and the step sequencer.
interface step_sequencer_if #(
   parameter int STEPS = 4
);
   localparam int W = $clog2(STEPS);

   logic             Run;
   logic             Hold;
   logic             Done;
   logic [W-1:0]     Last;
   logic [W-1:0]     CNT;
   logic [STEPS-1:0] T;
   logic             Busy;
   logic             Wrap;

   modport master (
      output Run, Hold, Done, Last,
      input  CNT, T, Busy, Wrap
   );

   modport slave (
      input  Run, Hold, Done, Last,
      output CNT, T, Busy, Wrap
   );
endinterface

// File: rtl/step_sequencer_onehot_decode.sv
// One-hot decode of a step index; indices at or above N light no bit.
module onehot_decode #(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic [W-1:0] idx_i,
   output logic [N-1:0] onehot_o
);

   // Compare the index against every legal position
   always_comb begin
      onehot_o = '0;
      for (int i = 0; i < N; i++) begin
         onehot_o[i] = (idx_i == W'(i));
      end
   end

endmodule

// File: rtl/step_sequencer.sv
// Timestep generator: sequences T0..T(Lim) per instruction with stall,
// early finish and a completion pulse. State advances on the falling edge.
module step_sequencer
   import step_seq_pkg::*;
#(
   parameter int STEPS = 4
) (
   input logic             CLKb,
   input logic             CLR,
   step_sequencer_if.slave bus
);

   localparam int W = $clog2(STEPS);
   localparam logic [W-1:0] LIM_MAX = W'(STEPS - 1);

   state_t       state_q, state_d;
   logic [W-1:0] cnt_q, cnt_d;
   logic [W-1:0] lim_q, lim_d;
   logic         wrap_q, wrap_d;
   logic [W-1:0] last_sat_s;
   logic         end_of_instr_s;

   // Clamp the requested last step so Lim (and therefore CNT) stays in range
   always_comb begin
      last_sat_s = W'(sat_last(32'(bus.Last), STEPS));
   end

   // Next-state logic; Hold outranks Done, Done/limit end an instruction
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      lim_d          = lim_q;
      wrap_d         = 1'b0;
      end_of_instr_s = bus.Done || (cnt_q == lim_q);
      case (state_q)
         IDLE: begin
            if (!bus.Hold && bus.Run) begin
               state_d = RUN;
               lim_d   = last_sat_s;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (bus.Hold) begin
               wrap_d = 1'b0;
            end else if (end_of_instr_s) begin
               cnt_d  = '0;
               wrap_d = 1'b1;
               if (bus.Run) begin
                  lim_d = last_sat_s;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + W'(1'b1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            lim_d   = LIM_MAX;
         end
      endcase
   end

   // Falling-edge state registers with asynchronous clear
   always_ff @(negedge CLKb or posedge CLR) begin
      if (CLR) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         lim_q   <= LIM_MAX;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lim_q   <= lim_d;
         wrap_q  <= wrap_d;
      end
   end

   onehot_decode #(.N(STEPS), .W(W)) u_decode (
      .idx_i    (cnt_q),
      .onehot_o (bus.T)
   );

   assign bus.CNT  = cnt_q;
   assign bus.Busy = (state_q == RUN);
   assign bus.Wrap = wrap_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer: STEPS=4 and STEPS=5 instances driven in
// parallel, compared against a rule-level reference model.
module tb_step_sequencer;

   logic       CLKb = 1'b1;
   logic       CLR;
   logic       run, hold, done;
   logic [2:0] last;
   int         checks = 0;
   int         errors = 0;

   step_sequencer_if #(.STEPS(4)) bus4 ();
   step_sequencer_if #(.STEPS(5)) bus5 ();

   step_sequencer #(.STEPS(4)) dut4 (.CLKb(CLKb), .CLR(CLR), .bus(bus4));
   step_sequencer #(.STEPS(5)) dut5 (.CLKb(CLKb), .CLR(CLR), .bus(bus5));

   assign bus4.Run  = run;
   assign bus4.Hold = hold;
   assign bus4.Done = done;
   assign bus4.Last = last[1:0];
   assign bus5.Run  = run;
   assign bus5.Hold = hold;
   assign bus5.Done = done;
   assign bus5.Last = last;

   always #5 CLKb = ~CLKb;

   // Reference model: index 0 is STEPS=4, index 1 is STEPS=5
   int m_steps [2] = '{4, 5};
   int m_busy  [2];
   int m_cnt   [2];
   int m_lim   [2];
   int m_wrap  [2];

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_busy[i] = 0;
         m_cnt[i]  = 0;
         m_wrap[i] = 0;
         m_lim[i]  = m_steps[i] - 1;
      end
   endtask

   task automatic model_edge();
      int lv, sat;
      if (CLR) begin
         model_reset();
      end else begin
         for (int i = 0; i < 2; i++) begin
            lv  = (i == 0) ? int'(last[1:0]) : int'(last);
            sat = (lv > m_steps[i] - 1) ? m_steps[i] - 1 : lv;
            if (m_busy[i] == 0) begin
               m_wrap[i] = 0;
               if (run && !hold) begin
                  m_busy[i] = 1;
                  m_lim[i]  = sat;
               end
            end else if (hold) begin
               m_wrap[i] = 0;
            end else if (done || m_cnt[i] == m_lim[i]) begin
               m_cnt[i]  = 0;
               m_wrap[i] = 1;
               if (run) m_lim[i] = sat;
               else     m_busy[i] = 0;
            end else begin
               m_cnt[i]  = m_cnt[i] + 1;
               m_wrap[i] = 0;
            end
         end
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [31:0] cnt_o, t_o, busy_o, wrap_o;
      for (int i = 0; i < 2; i++) begin
         cnt_o  = (i == 0) ? 32'(bus4.CNT)  : 32'(bus5.CNT);
         t_o    = (i == 0) ? 32'(bus4.T)    : 32'(bus5.T);
         busy_o = (i == 0) ? 32'(bus4.Busy) : 32'(bus5.Busy);
         wrap_o = (i == 0) ? 32'(bus4.Wrap) : 32'(bus5.Wrap);
         check($sformatf("%s_s%0d_cnt", tag, m_steps[i]), cnt_o, 32'(m_cnt[i]));
         check($sformatf("%s_s%0d_T", tag, m_steps[i]), t_o, 32'd1 << m_cnt[i]);
         check($sformatf("%s_s%0d_onehot", tag, m_steps[i]), 32'($countones(t_o)), 32'd1);
         check($sformatf("%s_s%0d_busy", tag, m_steps[i]), busy_o, 32'(m_busy[i]));
         check($sformatf("%s_s%0d_wrap", tag, m_steps[i]), wrap_o, 32'(m_wrap[i]));
      end
   endtask

   // One falling (active) edge, then compare on the following rising edge
   task automatic step(input string tag);
      @(negedge CLKb);
      model_edge();
      @(posedge CLKb);
      check_all(tag);
   endtask

   initial begin
      CLR  = 1'b1;
      run  = 1'b0;
      hold = 1'b0;
      done = 1'b0;
      last = 3'd0;
      model_reset();
      repeat (3) step("reset");
      check("reset_T4", 32'(bus4.T), 32'h1);
      check("reset_busy4", 32'(bus4.Busy), 32'h0);

      // Last=3, Run held: T0 T1 T2 T3 T0(wrap)
      CLR  = 1'b0;
      run  = 1'b1;
      last = 3'd3;
      step("start");
      check("start_cnt4", 32'(bus4.CNT), 32'd0);
      check("start_busy4", 32'(bus4.Busy), 32'd1);
      repeat (3) step("seq3");
      check("seq3_T3", 32'(bus4.T), 32'h8);
      step("seq3_wrap");
      check("seq3_wrap4", 32'(bus4.Wrap), 32'd1);
      check("seq3_wrap_cnt4", 32'(bus4.CNT), 32'd0);

      // Async clear at T2 without waiting for an edge
      repeat (2) step("to_t2");
      CLR = 1'b1;
      #1;
      model_reset();
      check_all("async_clr");
      check("async_clr_busy4", 32'(bus4.Busy), 32'd0);
      step("clr_held");
      CLR = 1'b0;

      // Last=1 back-to-back, then Last=3 sampled at the wrap
      last = 3'd1;
      repeat (4) step("last1");
      last = 3'd3;
      repeat (4) step("last1to3");
      check("last1to3_cnt4", 32'(bus4.CNT), 32'd3);

      // Hold two edges at T1, then Hold+Done at T2
      repeat (2) step("pre_hold");
      hold = 1'b1;
      repeat (2) step("hold");
      check("hold_cnt4", 32'(bus4.CNT), 32'd1);
      hold = 1'b0;
      step("after_hold");
      hold = 1'b1;
      done = 1'b1;
      step("hold_done");
      check("hold_done_cnt4", 32'(bus4.CNT), 32'd2);
      hold = 1'b0;
      done = 1'b0;
      repeat (2) step("finish");

      // Done at T1 with Run low: wrap and leave RUN
      step("to_t1");
      done = 1'b1;
      run  = 1'b0;
      step("done_t1");
      check("done_t1_wrap4", 32'(bus4.Wrap), 32'd1);
      check("done_t1_busy4", 32'(bus4.Busy), 32'd0);
      done = 1'b0;
      step("idle");

      // Last=7 saturates: STEPS=5 runs T0..T4
      run  = 1'b1;
      last = 3'd7;
      step("sat_start");
      repeat (4) step("sat");
      check("sat_cnt5", 32'(bus5.CNT), 32'd4);
      step("sat_wrap");
      check("sat_wrap_cnt5", 32'(bus5.CNT), 32'd0);
      run = 1'b0;
      repeat (5) step("drain");

      // Last=0: every RUN cycle is T0 with Wrap high
      run  = 1'b1;
      last = 3'd0;
      step("lim0_start");
      repeat (4) step("lim0");
      check("lim0_wrap5", 32'(bus5.Wrap), 32'd1);
      check("lim0_cnt4", 32'(bus4.CNT), 32'd0);

      // Randomized traffic with occasional asynchronous clears
      for (int n = 0; n < 400; n++) begin
         run  = ($urandom_range(0, 9) != 0);
         hold = ($urandom_range(0, 3) == 0);
         done = ($urandom_range(0, 4) == 0);
         last = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 49) == 0) begin
            CLR = 1'b1;
            #1;
            model_reset();
            check_all("rnd_clr");
            step("rnd_clr_edge");
            CLR = 1'b0;
         end else begin
            step("rnd");
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
